vmm_step_ctrl: RTL and testbench
================================

VMM_STEP_CTRL -- requirements
Module: vmm_step_ctrl

Interface
REQ-001 SHALL have parameter TOTAL, default 25, meaning number of VMM results per full run (l*n).
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, meaning auto-mode dwell cycles between results.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning WAIT_BCD watchdog limit.
REQ-004 SHALL have port step_clk, input, 1, meaning single clock, all logic on rising edge.
REQ-005 SHALL have port rst_, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port key_i, input, 1, meaning raw active-high step request (inverted KEY), asynchronous.
REQ-007 SHALL have port auto_i, input, 1, meaning auto-run enable (switch), asynchronous.
REQ-008 SHALL have port bcd_done_i, input, 1, meaning bin2bcd conversion complete, level.
REQ-009 SHALL have port next_o, output, 1, meaning one-cycle advance pulse to VMM next_i.
REQ-010 SHALL have port bcd_start_o, output, 1, meaning one-cycle start pulse to bin2bcd start_i.
REQ-011 SHALL have port busy_o, output, 1, meaning high in ISSUE, WAIT_BCD and HOLD.
REQ-012 SHALL have port run_done_o, output, 1, meaning high in FINISHED.
REQ-013 SHALL have port cnt_o, output, $clog2(TOTAL+1), meaning results issued this run.
REQ-014 SHALL have port state_o, output, 3, meaning current FSM state encoding.
REQ-015 SHALL have port err_o, output, 1, meaning sticky watchdog error.

Function
REQ-016 SHALL pass key_i and auto_i through a 2-flop synchronizer; key_i additionally rising-edge detected (one request per press).
REQ-017 SHALL implement states IDLE=0, ISSUE=1, WAIT_BCD=2, HOLD=3, FINISHED=4.
REQ-018 IDLE: key edge, or synced auto_i high, SHALL move to ISSUE next cycle.
REQ-019 ISSUE SHALL last exactly one cycle with next_o=bcd_start_o=1, increment cnt_o, then enter WAIT_BCD.
REQ-020 WAIT_BCD SHALL exit on first cycle bcd_done_i=1: to FINISHED if cnt_o==TOTAL, else HOLD if auto_i, else IDLE.
REQ-021 HOLD SHALL count HOLD_CYCLES cycles then go to ISSUE; auto_i dropping during HOLD SHALL return to IDLE next cycle.
REQ-022 FINISHED SHALL hold until key edge, which clears cnt_o to 0 and enters IDLE; auto_i alone SHALL NOT restart.
REQ-023 Key edges in ISSUE, WAIT_BCD, HOLD SHALL be discarded, not queued.
REQ-024 bcd_done_i SHALL be ignored outside WAIT_BCD.
REQ-025 Key edge and auto_i simultaneously in IDLE SHALL produce exactly one ISSUE.
REQ-026 Latency key_i rise to next_o SHALL be 4 cycles (2 sync, 1 edge, 1 IDLE->ISSUE).
REQ-027 cnt_o SHALL never exceed TOTAL; no wrap-around.

Reset
REQ-028 rst_ low SHALL immediately force IDLE, cnt_o=0, next_o=bcd_start_o=0, busy_o=run_done_o=err_o=0, synchronizers and counters 0.
REQ-029 Reset mid-run SHALL abandon the run; no pulse issued in the first cycle after release.

Configuration
REQ-030 With VMM_STEP_TIMEOUT_EN defined, WAIT_BCD exceeding TIMEOUT_CYCLES without bcd_done_i SHALL set err_o (sticky until reset) and go to IDLE.
REQ-031 Without VMM_STEP_TIMEOUT_EN, WAIT_BCD SHALL wait indefinitely, err_o tied 0, and no watchdog counter synthesized.

Structure
REQ-032 State encoding constants and the 3-bit state width SHALL live in shared package vmm_pkg.
REQ-033 Synchronizer plus edge detector SHALL be sub-module key_edge_sync, instantiated once for key_i.

Verification
REQ-034 Manual: reset, one key press, bcd_done_i after 10 cycles -> single next_o and bcd_start_o pulse, cnt_o=1, back to IDLE.
REQ-035 Auto: auto_i=1, bcd_done_i 3 cycles after each start, TOTAL=25 -> 25 pulses spaced by HOLD_CYCLES, run_done_o=1, cnt_o=25.
REQ-036 Key pressed during WAIT_BCD and HOLD -> no extra next_o, cnt_o unchanged by the press.
REQ-037 Reset asserted in HOLD with cnt_o=7 -> all outputs 0 immediately, IDLE after release.
REQ-038 VMM_STEP_TIMEOUT_EN defined, bcd_done_i held 0 -> err_o=1 after 64 WAIT_BCD cycles, IDLE; undefined -> stays WAIT_BCD, err_o=0.
REQ-039 FINISHED with auto_i=1 -> stays FINISHED; key press -> cnt_o=0, new run starts.

Source files
------------

// File: rtl/vmm_pkg.sv
// Shared definitions for the VMM step controller: FSM state encoding and width.
package vmm_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_BCD = 3'd2,
    ST_HOLD     = 3'd3,
    ST_FINISHED = 3'd4
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s == ST_ISSUE) || (s == ST_WAIT_BCD) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector:
// one single-cycle edge_o pulse per low-to-high transition of d_i.
module key_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic edge_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       edge_q;

  // Synchronize, remember the previous synced level and register the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      prev_q <= sync_q[1];
      edge_q <= sync_q[1] & ~prev_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/vmm_step_ctrl.sv
// Step/auto-run controller sequencing VMM results into a bin2bcd converter.
// Optional WAIT_BCD watchdog is built only with VMM_STEP_TIMEOUT_EN defined.
module vmm_step_ctrl
  import vmm_pkg::*;
#(
  parameter int TOTAL          = 25,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         step_clk,
  input  logic                         rst_,
  input  logic                         key_i,
  input  logic                         auto_i,
  input  logic                         bcd_done_i,
  output logic                         next_o,
  output logic                         bcd_start_o,
  output logic                         busy_o,
  output logic                         run_done_o,
  output logic [$clog2(TOTAL+1)-1:0]   cnt_o,
  output logic [STATE_W-1:0]           state_o,
  output logic                         err_o
);

  localparam int CNT_W  = $clog2(TOTAL + 1);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_TOTAL = CNT_W'(TOTAL);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [1:0]          auto_sync_q;
  logic                auto_s;
  logic                key_edge_s;
  logic                timeout_s;
  logic                next_q, next_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  key_edge_sync u_key_sync (
    .clk_i  (step_clk),
    .rst_ni (rst_),
    .d_i    (key_i),
    .edge_o (key_edge_s)
  );

  // Auto switch is a level, so a plain two-flop synchronizer is enough.
  always_ff @(posedge step_clk or negedge rst_) begin
    if (!rst_) begin
      auto_sync_q <= 2'b00;
    end else begin
      auto_sync_q <= {auto_sync_q[0], auto_i};
    end
  end

  assign auto_s = auto_sync_q[1];

`ifdef VMM_STEP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q;

  // Watchdog counts cycles spent in WAIT_BCD, restarting on every entry.
  always_comb begin
    wd_d = '0;
    if (state_q == ST_WAIT_BCD) begin
      wd_d = wd_q + WD_W'(1);
    end else begin
      wd_d = '0;
    end
  end

  assign timeout_s = (state_q == ST_WAIT_BCD) && !bcd_done_i && (wd_q == WD_LAST);

  always_ff @(posedge step_clk or negedge rst_) begin
    if (!rst_) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_q | timeout_s;
    end
  end

  assign err_o = err_q;
`else
  assign timeout_s = 1'b0;
  assign err_o     = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge step_clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic; key edges outside IDLE/FINISHED simply fall away.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (key_edge_s || auto_s) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BCD;
      end
      ST_WAIT_BCD: begin
        if (bcd_done_i) begin
          if (cnt_q == CNT_TOTAL) begin
            state_d = ST_FINISHED;
          end else if (auto_s) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (timeout_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_BCD;
        end
      end
      ST_HOLD: begin
        if (!auto_s) begin
          state_d = ST_IDLE;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_FINISHED: begin
        if (key_edge_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FINISHED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Result counter saturates at TOTAL; hold counter only runs while staying in HOLD.
  always_comb begin
    cnt_d  = cnt_q;
    hold_d = '0;
    if ((state_q == ST_ISSUE) && (cnt_q != CNT_TOTAL)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if ((state_q == ST_FINISHED) && key_edge_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q;
    end
    if ((state_q == ST_HOLD) && (state_d == ST_HOLD)) begin
      hold_d = hold_q + HOLD_W'(1);
    end else begin
      hold_d = '0;
    end
  end

  // Outputs decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    next_d  = (state_d == ST_ISSUE);
    start_d = (state_d == ST_ISSUE);
    busy_d  = is_busy(state_d);
    done_d  = (state_d == ST_FINISHED);
  end

  // Output registers.
  always_ff @(posedge step_clk or negedge rst_) begin
    if (!rst_) begin
      next_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      next_q  <= next_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign next_o      = next_q;
  assign bcd_start_o = start_q;
  assign busy_o      = busy_q;
  assign run_done_o  = done_q;
  assign cnt_o       = cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_vmm_step_ctrl.sv
// Self-checking bench for vmm_step_ctrl: manual vectors, corner sequences and a
// randomized auto run checked against a pulse-timeline model.
module tb_vmm_step_ctrl;
  import vmm_pkg::*;

  localparam int TOTAL = 25;
  localparam int HOLD  = 4;
  localparam int TMO   = 64;
  localparam int CW    = $clog2(TOTAL + 1);

  logic          step_clk;
  logic          rst_;
  logic          key_i;
  logic          auto_i;
  logic          bcd_done_i;
  logic          next_o;
  logic          bcd_start_o;
  logic          busy_o;
  logic          run_done_o;
  logic [CW-1:0] cnt_o;
  logic [2:0]    state_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_q[$];
  int delay_q[$];
  int pulse_mism = 0;
  bit resp_en;
  int resp_fixed;

  vmm_step_ctrl #(.TOTAL(TOTAL), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
    .step_clk    (step_clk),
    .rst_        (rst_),
    .key_i       (key_i),
    .auto_i      (auto_i),
    .bcd_done_i  (bcd_done_i),
    .next_o      (next_o),
    .bcd_start_o (bcd_start_o),
    .busy_o      (busy_o),
    .run_done_o  (run_done_o),
    .cnt_o       (cnt_o),
    .state_o     (state_o),
    .err_o       (err_o)
  );

  initial begin
    step_clk = 1'b0;
    forever #5 step_clk = ~step_clk;
  end

  always @(posedge step_clk) cyc <= cyc + 1;

  // Pulse monitor: records the cycle of every advance pulse.
  initial begin
    forever begin
      @(negedge step_clk);
      if (next_o || bcd_start_o) begin
        if (next_o !== bcd_start_o) pulse_mism++;
        pulse_q.push_back(cyc);
      end
    end
  end

  // bin2bcd responder: raises done for one cycle D cycles after each start.
  initial begin
    int d;
    bcd_done_i = 1'b0;
    forever begin
      @(negedge step_clk);
      if (resp_en && bcd_start_o) begin
        d = (resp_fixed > 0) ? resp_fixed : int'($urandom_range(1, 6));
        delay_q.push_back(d);
        repeat (d) @(posedge step_clk);
        #1 bcd_done_i = 1'b1;
        @(posedge step_clk);
        #1 bcd_done_i = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_next"},  int'(next_o), 0);
    check({tag, "_start"}, int'(bcd_start_o), 0);
    check({tag, "_busy"},  int'(busy_o), 0);
    check({tag, "_done"},  int'(run_done_o), 0);
    check({tag, "_err"},   int'(err_o), 0);
    check({tag, "_cnt"},   int'(cnt_o), 0);
    check({tag, "_state"}, int'(state_o), int'(ST_IDLE));
  endtask

  task automatic wait_state(input int st, input int budget, input string name);
    int n;
    n = 0;
    while ((int'(state_o) != st) && (n < budget)) begin
      @(negedge step_clk);
      n++;
    end
    check(name, int'(state_o), st);
  endtask

  task automatic press_key(output int t);
    @(posedge step_clk);
    #1;
    t = cyc;
    key_i = 1'b1;
    repeat (3) @(posedge step_clk);
    #1 key_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge step_clk);
    rst_ = 1'b0;
    repeat (2) @(negedge step_clk);
    rst_ = 1'b1;
  endtask

  typedef struct {
    int delay;
    bit repress;
    int exp_cnt;
    int exp_pulses;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int b, db, t0, t1, tdone, n;

    tbl[0] = '{1,  1'b0, 2, 1};
    tbl[1] = '{5,  1'b0, 3, 1};
    tbl[2] = '{12, 1'b1, 4, 1};
    tbl[3] = '{3,  1'b0, 5, 1};

    rst_ = 1'b1; key_i = 1'b0; auto_i = 1'b0; resp_en = 1'b1; resp_fixed = 4;
    #1 rst_ = 1'b0;
    #2 check_zero("reset");
    repeat (3) @(posedge step_clk);
    #1 rst_ = 1'b1;

    // Single manual step with a slow converter, including key-to-pulse latency.
    resp_fixed = 10;
    b = pulse_q.size();
    press_key(t0);
    wait_state(int'(ST_WAIT_BCD), 10, "manual_wait");
    t1 = (pulse_q.size() > b) ? pulse_q[b] : -1000;
    check("latency", t1 - t0, 4);
    check("manual_busy", int'(busy_o), 1);
    wait_state(int'(ST_IDLE), 30, "manual_idle");
    check("manual_cnt", int'(cnt_o), 1);
    check("manual_pulses", pulse_q.size() - b, 1);

    for (int i = 0; i < 4; i++) begin
      resp_fixed = tbl[i].delay;
      b = pulse_q.size();
      press_key(t0);
      wait_state(int'(ST_WAIT_BCD), 10, $sformatf("vec%0d_wait", i));
      if (tbl[i].repress) press_key(t1);
      wait_state(int'(ST_IDLE), 40, $sformatf("vec%0d_idle", i));
      repeat (6) @(negedge step_clk);
      check($sformatf("vec%0d_cnt", i), int'(cnt_o), tbl[i].exp_cnt);
      check($sformatf("vec%0d_pulses", i), pulse_q.size() - b, tbl[i].exp_pulses);
      check($sformatf("vec%0d_state", i), int'(state_o), int'(ST_IDLE));
    end

    // Key edge and auto together in IDLE give one ISSUE.
    resp_fixed = 8;
    b = pulse_q.size();
    @(posedge step_clk);
    #1 key_i = 1'b1; auto_i = 1'b1;
    repeat (3) @(posedge step_clk);
    #1 key_i = 1'b0; auto_i = 1'b0;
    repeat (20) @(negedge step_clk);
    check("both_pulses", pulse_q.size() - b, 1);
    check("both_cnt", int'(cnt_o), 6);
    check("both_state", int'(state_o), int'(ST_IDLE));

    // Randomized full auto run with stray key presses while busy.
    do_reset();
    check("rerun_cnt", int'(cnt_o), 0);
    b = pulse_q.size();
    db = delay_q.size();
    resp_fixed = 0;
    auto_i = 1'b1;
    n = 0;
    while (!run_done_o && (n < 1500)) begin
      @(negedge step_clk);
      n++;
      if ((pulse_q.size() - b) < 20) begin
        if (cyc % 8 == 0) key_i = ($urandom_range(0, 1) == 1);
      end else begin
        key_i = 1'b0;
      end
    end
    tdone = cyc;
    key_i = 1'b0;
    check("auto_finished", int'(run_done_o), 1);
    check("auto_pulses", pulse_q.size() - b, TOTAL);
    check("auto_cnt", int'(cnt_o), TOTAL);
    check("auto_busy", int'(busy_o), 0);
    if ((pulse_q.size() - b == TOTAL) && (delay_q.size() - db >= TOTAL)) begin
      for (int k = 0; k < TOTAL - 1; k++) begin
        check($sformatf("auto_gap%0d", k), pulse_q[b+k+1] - pulse_q[b+k],
              delay_q[db+k] + 1 + HOLD);
      end
      check("auto_done_time", tdone, pulse_q[b+TOTAL-1] + delay_q[db+TOTAL-1] + 1);
    end

    // FINISHED ignores auto, a key press restarts from zero.
    b = pulse_q.size();
    repeat (20) @(negedge step_clk);
    check("fin_hold_state", int'(state_o), int'(ST_FINISHED));
    check("fin_hold_pulses", pulse_q.size() - b, 0);
    resp_fixed = 1;
    press_key(t0);
    wait_state(int'(ST_IDLE), 10, "fin_to_idle");
    check("fin_clear_cnt", int'(cnt_o), 0);

    // Reset while in HOLD with seven results issued.
    n = 0;
    while (!((int'(cnt_o) == 7) && (int'(state_o) == int'(ST_HOLD))) && (n < 200)) begin
      @(negedge step_clk);
      n++;
    end
    check("hold7_reached", int'(cnt_o), 7);
    #1 rst_ = 1'b0;
    #1 check_zero("hold_reset");
    b = pulse_q.size();
    repeat (2) @(negedge step_clk);
    rst_ = 1'b1;
    @(negedge step_clk);
    check("post_reset_next", int'(next_o), 0);
    check("post_reset_state", int'(state_o), int'(ST_IDLE));
    check("post_reset_pulses", pulse_q.size() - b, 0);

    // Auto dropping in the first HOLD cycle returns to IDLE without another pulse.
    wait_state(int'(ST_HOLD), 40, "drop_hold");
    auto_i = 1'b0;
    b = pulse_q.size();
    repeat (12) @(negedge step_clk);
    check("drop_pulses", pulse_q.size() - b, 0);
    check("drop_state", int'(state_o), int'(ST_IDLE));

    // Converter never answers.
    resp_en = 1'b0;
    press_key(t0);
    wait_state(int'(ST_WAIT_BCD), 10, "stuck_wait");
`ifdef VMM_STEP_TIMEOUT_EN
    repeat (TMO - 1) @(negedge step_clk);
    check("wd_before_state", int'(state_o), int'(ST_WAIT_BCD));
    check("wd_before_err", int'(err_o), 0);
    @(negedge step_clk);
    check("wd_state", int'(state_o), int'(ST_IDLE));
    check("wd_err", int'(err_o), 1);
`else
    repeat (100) @(negedge step_clk);
    check("stuck_state", int'(state_o), int'(ST_WAIT_BCD));
    check("stuck_err", int'(err_o), 0);
`endif

    check("pulse_pair", pulse_mism, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
